// File: rtl/r0_alu_sequencer.sv
// rtl/r0_alu_sequencer.sv - multi-cycle ALU sequencer: ADD/SUB/NEG in one step, radix-2 Booth MUL
module r0_alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   value1,
    input  logic [WIDTH-1:0]   value2,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   output1,
    output logic [WIDTH-1:0]   output2,
    output logic               carry,
    output logic               zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_NEG = 2'd3;

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [CNT_W-1:0]   cnt;

    // Booth datapath: acc is one bit wider than the operands so that
    // subtracting the most-negative multiplicand cannot overflow.
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   mq;
    logic               q_m1;

    logic [WIDTH:0]     calc_res;
    logic               calc_carry;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     acc_add;
    logic [2*WIDTH+1:0] booth_cat;
    logic [2*WIDTH+1:0] booth_sh;
    logic [2*WIDTH-1:0] product;
    logic               accept;

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign m_ext   = {b_q[WIDTH-1], b_q};
    assign product = {acc[WIDTH-1:0], mq};

    // Single-step result for ADD/SUB/NEG; the extra MSB is the carry-out
    always_comb begin
        calc_res   = '0;
        calc_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                calc_res   = {1'b0, a_q} + {1'b0, b_q};
                calc_carry = calc_res[WIDTH];
            end
            OP_SUB: begin
                calc_res   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
                calc_carry = calc_res[WIDTH];
            end
            OP_NEG: begin
                calc_res   = {1'b0, ~a_q} + {{WIDTH{1'b0}}, 1'b1};
                calc_carry = 1'b0;
            end
            default: begin
                calc_res   = '0;
                calc_carry = 1'b0;
            end
        endcase
    end

    // One Booth iteration: add/subtract multiplicand, then arithmetic shift right
    always_comb begin
        acc_add = acc;
        case ({mq[0], q_m1})
            2'b01:   acc_add = acc + m_ext;
            2'b10:   acc_add = acc - m_ext;
            default: acc_add = acc;
        endcase
        booth_cat = {acc_add, mq, q_m1};
        booth_sh  = {booth_cat[2*WIDTH+1], booth_cat[2*WIDTH+1:1]};
    end

    // Sequencer FSM with registered outputs; done is cleared every edge regardless of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            acc     <= '0;
            mq      <= '0;
            q_m1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            output1 <= '0;
            output2 <= '0;
            carry   <= 1'b0;
            zero    <= 1'b1;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (state)
                    IDLE, DONE: begin
                        if (accept) begin
                            op_q <= op;
                            a_q  <= value1;
                            b_q  <= value2;
                            busy <= 1'b1;
                            if (op == OP_MUL) begin
                                state <= MULT;
                                cnt   <= CNT_W'(WIDTH);
                                acc   <= '0;
                                mq    <= value1;
                                q_m1  <= 1'b0;
                            end else begin
                                state <= CALC;
                            end
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    CALC: begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        output1 <= calc_res[WIDTH-1:0];
                        output2 <= '0;
                        carry   <= calc_carry;
                        zero    <= (calc_res[WIDTH-1:0] == '0);
                    end
                    MULT: begin
                        if (cnt != '0) begin
                            acc  <= booth_sh[2*WIDTH+1:WIDTH+1];
                            mq   <= booth_sh[WIDTH:1];
                            q_m1 <= booth_sh[0];
                            cnt  <= cnt - 1'b1;
                        end else begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            output1 <= product[2*WIDTH-1:WIDTH];
                            output2 <= product[WIDTH-1:0];
                            carry   <= 1'b0;
                            zero    <= (product == '0);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
